// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix-keypad scan controller.
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      SINGLE = 2'd1,
      MULTI  = 2'd2
   } scan_res_e;

   function automatic int code_width(input int rows, input int cols);
      return (rows * cols > 1) ? $clog2(rows * cols) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to all-ones
// so idle (pulled-up) pins read as released.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column-scanning keypad controller with one shared debounce tracker that
// accepts a key only after several consecutive identical full scans.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int  N_ROWS       = 4,
   parameter int  N_COLS       = 4,
   parameter int  SCAN_CYCLES  = 1000,
   parameter int  STABLE_SCANS = 4,
   localparam int CW           = code_width(N_ROWS, N_COLS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_ROWS-1:0] row_async,
   output logic [N_COLS-1:0] col_drive,
   output logic [CW-1:0]     key_code,
   output logic              key_valid,
   output logic              key_held,
   output logic [1:0]        dbg_state
);

   localparam int DW   = $clog2(SCAN_CYCLES);
   localparam int CIW  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
   localparam int RIW  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
   localparam int CNTW = $clog2(STABLE_SCANS + 1);

   localparam logic [1:0] ST_IDLE     = IDLE;
   localparam logic [1:0] ST_DEBOUNCE = DEBOUNCE;
   localparam logic [1:0] ST_HELD     = HELD;
   localparam logic [1:0] ST_RELEASE  = RELEASE;

   logic [N_ROWS-1:0] row_s;

   sync_2ff #(.WIDTH(N_ROWS)) u_row_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (row_async),
      .q     (row_s)
   );

   // Scan sequencing; run holds off the first dwell until col 0 is actually driven.
   logic           run;
   logic [DW-1:0]  dwell_cnt;
   logic [CIW-1:0] col_idx;
   logic [CIW-1:0] col_nxt;
   logic           sample;
   logic           scan_done;

   assign sample    = run && (dwell_cnt == DW'(SCAN_CYCLES - 1));
   assign scan_done = sample && (col_idx == CIW'(N_COLS - 1));
   assign col_nxt   = (col_idx == CIW'(N_COLS - 1)) ? '0 : col_idx + CIW'(1);

   function automatic logic [N_COLS-1:0] drive_for(input logic [CIW-1:0] idx);
      logic [N_COLS-1:0] v;
      for (int c = 0; c < N_COLS; c++) begin
         v[c] = (CIW'(c) != idx);
      end
      return v;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run       <= 1'b0;
         dwell_cnt <= '0;
         col_idx   <= '0;
         col_drive <= '1;
      end else if (!run) begin
         run       <= 1'b1;
         col_drive <= drive_for('0);
      end else if (sample) begin
         dwell_cnt <= '0;
         col_idx   <= col_nxt;
         col_drive <= drive_for(col_nxt);
      end else begin
         dwell_cnt <= dwell_cnt + DW'(1);
      end
   end

   // Per-column classification of closed rows.
   logic [N_ROWS-1:0] z;
   logic              col_any;
   logic              col_multi;
   logic [RIW-1:0]    row_idx;
   logic [CW-1:0]     col_code;

   assign z         = ~row_s;
   assign col_any   = |z;
   assign col_multi = |(z & (z - N_ROWS'(1)));
   assign col_code  = CW'(int'(col_idx) * N_ROWS + int'(row_idx));

   always_comb begin
      row_idx = '0;
      for (int r = 0; r < N_ROWS; r++) begin
         if (z[r]) row_idx = RIW'(r);
      end
   end

   // Scan accumulator; scan_res/scan_code fold in the column being sampled now.
   scan_res_e     acc_res;
   logic [CW-1:0] acc_code;
   scan_res_e     scan_res;
   logic [CW-1:0] scan_code;

   always_comb begin
      scan_res  = acc_res;
      scan_code = acc_code;
      if (col_multi) begin
         scan_res = MULTI;
      end else if (col_any) begin
         if (acc_res == NONE) begin
            scan_res  = SINGLE;
            scan_code = col_code;
         end else begin
            scan_res = MULTI;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_res  <= NONE;
         acc_code <= '0;
      end else if (scan_done) begin
         acc_res  <= NONE;
         acc_code <= '0;
      end else if (sample) begin
         acc_res  <= scan_res;
         acc_code <= scan_code;
      end
   end

   // Debounce FSM, stepped once per completed scan.
   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [CW-1:0]   cand;
   logic [CW-1:0]   cand_nxt;
   logic [CNTW-1:0] cnt;
   logic [CNTW-1:0] cnt_nxt;
   logic [CNTW-1:0] cnt_inc;
   logic            accept;
   logic            same_key;

   assign cnt_inc   = cnt + CNTW'(1);
   assign same_key  = (scan_res == SINGLE) && (scan_code == cand);
   assign dbg_state = state;

   always_comb begin
      state_nxt = state;
      cand_nxt  = cand;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      if (scan_done) begin
         case (state)
            ST_IDLE: begin
               if (scan_res == SINGLE) begin
                  cand_nxt = scan_code;
                  cnt_nxt  = CNTW'(1);
                  if (STABLE_SCANS == 1) begin
                     state_nxt = ST_HELD;
                     accept    = 1'b1;
                  end else begin
                     state_nxt = ST_DEBOUNCE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (same_key) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc == CNTW'(STABLE_SCANS)) begin
                     state_nxt = ST_HELD;
                     accept    = 1'b1;
                  end
               end else if (scan_res == SINGLE) begin
                  cand_nxt = scan_code;
                  cnt_nxt  = CNTW'(1);
               end else begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
               end
            end
            ST_HELD: begin
               // Any other key activity is ignored until a release completes.
               if (scan_res == NONE) begin
                  if (STABLE_SCANS == 1) begin
                     state_nxt = ST_IDLE;
                     cnt_nxt   = '0;
                  end else begin
                     state_nxt = ST_RELEASE;
                     cnt_nxt   = CNTW'(1);
                  end
               end
            end
            default: begin
               if (scan_res == NONE) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc == CNTW'(STABLE_SCANS)) begin
                     state_nxt = ST_IDLE;
                     cnt_nxt   = '0;
                  end
               end else if (same_key) begin
                  state_nxt = ST_HELD;
                  cnt_nxt   = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cand      <= '0;
         cnt       <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_nxt;
         cand      <= cand_nxt;
         cnt       <= cnt_nxt;
         key_valid <= accept;
         key_held  <= (state_nxt == ST_HELD) || (state_nxt == ST_RELEASE);
         if (accept) key_code <= cand_nxt;
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a keypad matrix model drives the rows,
// accepted presses are checked against a queue of expected key codes.
module tb_keypad_scan_ctrl;
   import keypad_pkg::*;

   localparam int N_ROWS = 4;
   localparam int N_COLS = 4;
   localparam int CW     = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [N_ROWS-1:0] row_async;
   logic [N_COLS-1:0] col_drive;
   logic [CW-1:0]     key_code;
   logic              key_valid;
   logic              key_held;
   logic [1:0]        dbg_state;

   logic [15:0]       keys = '0;
   logic [CW-1:0]     exp_q[$];
   logic [CW-1:0]     exp_code;
   int                vectors = 0;
   int                miscompares = 0;

   keypad_scan_ctrl #(
      .N_ROWS       (N_ROWS),
      .N_COLS       (N_COLS),
      .SCAN_CYCLES  (4),
      .STABLE_SCANS (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_async (row_async),
      .col_drive (col_drive),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held),
      .dbg_state (dbg_state)
   );

   // Clock and keypad matrix model.
   always #5 clk = ~clk;

   always_comb begin
      row_async = '1;
      for (int c = 0; c < N_COLS; c++) begin
         for (int r = 0; r < N_ROWS; r++) begin
            if (keys[c*N_ROWS+r] && !col_drive[c]) row_async[r] = 1'b0;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One scan = 4 columns x 4 cycles; stimulus stays aligned to scan starts.
   task automatic scans(input int n);
      repeat (16 * n) @(negedge clk);
   endtask

   task automatic drained(input string name);
      #1;
      check(name, exp_q.size(), 0);
   endtask

   // Monitor: every key_valid pulse must match the oldest expected code.
   always @(negedge clk) begin
      if (rst_n && key_valid === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_pulse: key_valid=1 with code %0d, none expected", key_code);
         end else begin
            exp_code = exp_q.pop_front();
            if (key_code !== exp_code) begin
               miscompares++;
               $display("FAIL pulse_code: got %0d, expected %0d", key_code, exp_code);
            end
         end
      end
   end

   initial begin
      // 1: reset values, then column sequence with no keys
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_col_drive", col_drive, 15);
      check("rst_key_code", key_code, 0);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_held", key_held, 0);
      check("rst_state", dbg_state, IDLE);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("col_seq_%0d", i), col_drive, 15 ^ (1 << (i / 4)));
         @(negedge clk);
      end
      scans(1);
      check("t1_held", key_held, 0);

      // 2: key 9 (col 2, row 1) for 5 scans, then release
      exp_q.push_back(4'd9);
      keys[9] = 1'b1;
      scans(2);
      check("t2_held_early", key_held, 0);
      check("t2_state_deb", dbg_state, DEBOUNCE);
      scans(1);
      drained("t2_pulse_seen");
      check("t2_held", key_held, 1);
      check("t2_code", key_code, 9);
      scans(2);
      keys = '0;
      scans(2);
      check("t2_held_releasing", key_held, 1);
      check("t2_state_rel", dbg_state, RELEASE);
      scans(1);
      check("t2_released", key_held, 0);
      check("t2_state_idle", dbg_state, IDLE);

      // 3: present, absent, present x3
      exp_q.push_back(4'd9);
      keys[9] = 1'b1; scans(1);
      keys = '0;      scans(1);
      keys[9] = 1'b1; scans(2);
      check("t3_no_pulse_yet", key_held, 0);
      scans(1);
      drained("t3_pulse_seen");
      check("t3_held", key_held, 1);
      keys = '0;
      scans(3);
      check("t3_released", key_held, 0);

      // 4: keys 9 and 4 together are ambiguous
      keys[9] = 1'b1; keys[4] = 1'b1;
      scans(5);
      check("t4_held", key_held, 0);
      check("t4_code_kept", key_code, 9);
      check("t4_state", dbg_state, IDLE);
      keys = '0;
      scans(1);

      // 5: held key blocks others; short release bounces back to HELD
      exp_q.push_back(4'd9);
      keys[9] = 1'b1;
      scans(3);
      drained("t5_pulse9_seen");
      check("t5_held", key_held, 1);
      keys = '0;
      scans(1);
      check("t5_state_rel", dbg_state, RELEASE);
      keys[9] = 1'b1;
      scans(1);
      check("t5_state_back_held", dbg_state, HELD);
      check("t5_held_back", key_held, 1);
      keys[4] = 1'b1;
      scans(2);
      check("t5_multi_stays", dbg_state, HELD);
      keys[9] = 1'b0;
      scans(2);
      check("t5_other_stays", dbg_state, HELD);
      check("t5_code_still9", key_code, 9);
      keys = '0;
      scans(3);
      check("t5_released", key_held, 0);
      exp_q.push_back(4'd4);
      keys[4] = 1'b1;
      scans(3);
      drained("t5_pulse4_seen");
      check("t5_code4", key_code, 4);
      keys = '0;
      scans(3);
      check("t5_released4", key_held, 0);
      check("t5_code_holds", key_code, 4);

      // 6: reset in DEBOUNCE with cnt = 2 restarts the count
      keys[9] = 1'b1;
      scans(2);
      check("t6_state_deb", dbg_state, DEBOUNCE);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t6_rst_col_drive", col_drive, 15);
      check("t6_rst_code", key_code, 0);
      check("t6_rst_valid", key_valid, 0);
      check("t6_rst_held", key_held, 0);
      check("t6_rst_state", dbg_state, IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      scans(2);
      check("t6_no_pulse_held", key_held, 0);
      check("t6_state_deb2", dbg_state, DEBOUNCE);
      keys = '0;
      scans(2);
      check("t6_state_idle", dbg_state, IDLE);
      check("t6_code_zero", key_code, 0);

      repeat (5) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Matrix-keypad scan controller. It drives one column low at a time, samples the synchronised row inputs, and debounces across whole scans.
- It replaces per-button debouncers with a single shared, time-multiplexed debounce state. Only one candidate key is tracked at a time.
- Sits between the board keypad pins and the user-logic command decoder. Emits one key code plus a one-cycle press pulse.

Parameters:
- N_ROWS, 4, number of row inputs (active-low, pulled up externally).
- N_COLS, 4, number of column drive outputs (active-low).
- SCAN_CYCLES, 1000, clock cycles each column is driven (dwell, ≥2).
- STABLE_SCANS, 4, consecutive matching full scans needed for press/release (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- row_async  in  N_ROWS  raw row pins; 0 = key closed on driven column.
- col_drive  out  N_COLS  one-hot-low column drive; all-ones = no column driven.
- key_code  out  CW = $clog2(N_ROWS*N_COLS)  code = col*N_ROWS + row of the last accepted key.
- key_valid  out  1  one-cycle pulse when a press is accepted.
- key_held  out  1  level; 1 while the accepted key is considered pressed.

Behaviour:
- Reset values (async, rst_n low):
  - col_drive = all-ones; key_code = 0; key_valid = 0; key_held = 0.
  - Sync flops = all-ones. State IDLE; all counters 0.
- Input synchronisation: row_async passes through a 2-FF synchroniser (row_s).
- Scan sequencing:
  - First cycle after reset release, col_drive drives col 0 low.
  - dwell_cnt counts 0..SCAN_CYCLES-1. On the last dwell cycle, row_s is sampled for the current column and col_idx advances. col_idx wraps N_COLS-1 -> 0.
  - col_drive updates on the cycle after the sample.
  - scan_done is an internal pulse on the sample cycle of col N_COLS-1. Scan period = N_COLS*SCAN_CYCLES cycles.
- Per-scan result, accumulated over the scan:
  - none: no zero row seen.
  - single(code): exactly one closed key.
  - multi: two or more closed keys. A multi scan is ambiguous.
- FSM, evaluated only on scan_done:
  - IDLE:
    - single(c) -> DEBOUNCE, cand = c, cnt = 1.
    - If STABLE_SCANS = 1, go straight to HELD and pulse instead.
  - DEBOUNCE:
    - single(cand): cnt+1. Reaching STABLE_SCANS -> HELD, key_code = cand, key_valid = 1 for one cycle, key_held = 1.
    - single(other): restart with cand = other, cnt = 1.
    - none or multi -> IDLE.
  - HELD:
    - none -> RELEASE, cnt = 1 (with STABLE_SCANS = 1: straight to IDLE, key_held = 0).
    - single(cand), single(other), or multi -> stay. A new key requires a release first.
  - RELEASE:
    - none: cnt+1. Reaching STABLE_SCANS -> IDLE, key_held = 0.
    - single(cand) -> HELD, with no new pulse.
    - single(other) -> stay, cnt unchanged.
    - multi -> ignored, cnt unchanged.
- Latency:
  - key_valid fires on the scan_done cycle of the STABLE_SCANS-th consecutive matching scan.
  - key_valid and key_held are registered and appear the cycle after scan_done.
- key_code holds its value after release until the next accepted press.
- Counters saturate-free: widths are sized from the parameters; no wrap inside the valid range.
- Reset mid-scan: everything returns to reset values immediately; no pulse is generated on reset release.

Decomposition:
- Package keypad_pkg holds:
  - state enum {IDLE, DEBOUNCE, HELD, RELEASE}.
  - scan result enum {NONE, SINGLE, MULTI}.
  - function code_width(rows, cols).
- One sub-module: sync_2ff (parameterised width, reset value all-ones) for row synchronisation.

Test Plan (N_ROWS=4, N_COLS=4, SCAN_CYCLES=4, STABLE_SCANS=3; scan = 16 cycles):
1. Reset, no keys -> col_drive cycles 1110, 1101, 1011, 0111, each 4 cycles, starting the first cycle after rst_n rises; key_valid stays 0.
2. Press col 2 / row 1 (row_async[1]=0 while col_drive[2]=0) held for 5 scans -> exactly one key_valid pulse after the 3rd scan; key_code = 9; key_held = 1. Release -> key_held drops after 3 empty scans.
3. Press key 9 with 1-scan glitches (present, absent, present, present) -> no pulse until 3 consecutive present scans after the gap.
4. Press keys 9 and 4 simultaneously for 5 scans -> no key_valid (multi); key_code unchanged.
5. While key 9 is HELD, press key 4 additionally, then release 9 with 4 still held -> no pulse for 4 until 4 is released and re-pressed. 1 empty scan inside RELEASE followed by key 9 -> back to HELD with no pulse.
6. Assert rst_n low mid-DEBOUNCE (cnt = 2) -> outputs return to reset values at once; after release, key held 2 more scans gives no pulse (count restarts).
